switch_conditioner: RTL and testbench
=====================================

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000, meaning CLK cycles per debounce tick (1 ms at 12 MHz).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 20, meaning consecutive stable ticks required to accept a new level (legal range 1..255).
REQ-003 SHALL have port CLK  input  1  system clock, single clock domain.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SWITCH  input  4  raw asynchronous switch levels, active-low (0 = pressed).
REQ-006 SHALL have port oSWITCH  output  4  debounced switch levels, active-low, registered.
REQ-007 SHALL have port PRESS  output  4  one-cycle pulse per channel on accepted 1->0 transition.
REQ-008 SHALL have port RELEASE  output  4  one-cycle pulse per channel on accepted 0->1 transition.

Function
REQ-009 SHALL pass each SWITCH bit through a 2-flop synchronizer; both flops reset to 1.
REQ-010 SHALL generate an internal tick: a counter runs 0..TICK_DIV-1, wraps to 0, and asserts tick for one cycle at count TICK_DIV-1.
REQ-011 SHALL keep an 8-bit stability counter per channel, cleared in any cycle where the synchronized bit equals oSWITCH[i].
REQ-012 SHALL increment the channel counter on each tick while the synchronized bit differs from oSWITCH[i].
REQ-013 SHALL, in the cycle the counter reaches DEBOUNCE_TICKS, update oSWITCH[i] to the synchronized bit on the next edge and clear the counter; no wrap or saturation occurs.
REQ-014 SHALL assert PRESS[i] or RELEASE[i] for exactly one cycle, in the same cycle oSWITCH[i] changes value.
REQ-015 SHALL treat channels independently; simultaneous transitions on several channels update all of them in the same cycle.
REQ-016 SHALL reject any input disturbance shorter than DEBOUNCE_TICKS consecutive ticks (oSWITCH and pulses unchanged).
REQ-017 SHALL have latency, from a clean SWITCH edge to oSWITCH change, between (DEBOUNCE_TICKS-1)*TICK_DIV+3 and DEBOUNCE_TICKS*TICK_DIV+3 CLK cycles.
REQ-018 SHALL never assert PRESS[i] and RELEASE[i] in the same cycle.

Reset
REQ-019 SHALL, while RST_N=0, force oSWITCH=4'b1111, PRESS=4'b0000, RELEASE=4'b0000, synchronizer flops=1, and all counters=0, regardless of SWITCH.
REQ-020 SHALL, after reset is released mid-debounce, restart qualification from zero, requiring the full DEBOUNCE_TICKS again.
REQ-021 SHALL produce no PRESS/RELEASE pulse as a result of reset assertion or release alone.

Structure
REQ-022 SHALL place the channel count (4), the released level (1'b1), and the default TICK_DIV/DEBOUNCE_TICKS values in the shared project constants package.
REQ-023 SHALL implement one sub-module, switch_channel, containing the synchronizer, stability counter, level register, and edge pulses for one bit, instantiated 4 times.
REQ-024 SHALL share the single tick generator across all channels, located in switch_conditioner.

Verification (bench parameters TICK_DIV=4, DEBOUNCE_TICKS=3)
REQ-025 SHALL cover: RST_N=0 with SWITCH=4'b0000 -> oSWITCH=4'b1111, PRESS=RELEASE=0; release reset, hold SWITCH=4'b1111 -> no pulses.
REQ-026 SHALL cover: SWITCH[3] 1->0 and held -> oSWITCH[3]=0 within 11..15 cycles, with PRESS=4'b1000 for exactly one cycle.
REQ-027 SHALL cover: SWITCH[0] toggled with low pulses of 1 tick and 2 ticks -> oSWITCH[0] stays 1, PRESS stays 0.
REQ-028 SHALL cover: SWITCH[1] and SWITCH[2] fall in the same cycle -> both bits fall in the same cycle with PRESS=4'b0110, then both released -> RELEASE=4'b0110 for one cycle.
REQ-029 SHALL cover: SWITCH[3] held low, RST_N pulsed low after 2 ticks -> oSWITCH=4'b1111, with the 0 accepted only a full 3 ticks after reset release.
REQ-030 SHALL cover: the SWITCH[3] low level accepted in REQ-029 is then returned to 1 and held -> RELEASE=4'b1000 one cycle, oSWITCH=4'b1111.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// Shared constants for the switch conditioner: channel count, idle level
// and default timing parameters.
package switch_conditioner_pkg;

  localparam int   NUM_CH             = 4;
  localparam logic RELEASED_LVL       = 1'b1;
  localparam int   DEF_TICK_DIV       = 12000;
  localparam int   DEF_DEBOUNCE_TICKS = 20;
  localparam int   STAB_CNT_W         = 8;

  typedef logic [STAB_CNT_W-1:0] stab_cnt_t;

endpackage

// File: rtl/switch_channel.sv
// One debounced switch bit: 2-flop synchronizer, stability counter,
// accepted-level register and registered press/release pulses.
module switch_channel
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam stab_cnt_t DONE_CNT = stab_cnt_t'(DEBOUNCE_TICKS);

  logic      sync1_r;
  logic      sync2_r;
  stab_cnt_t cnt_r;
  logic      level_r;
  logic      press_r;
  logic      rel_r;

  // Synchronize, qualify the new level over DEBOUNCE_TICKS ticks, then accept it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= RELEASED_LVL;
      sync2_r <= RELEASED_LVL;
      cnt_r   <= {STAB_CNT_W{1'b0}};
      level_r <= RELEASED_LVL;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {STAB_CNT_W{1'b0}};
      end else if (cnt_r == DONE_CNT) begin
        // The counter only reaches DONE_CNT while the level differs, so the
        // pulse direction follows directly from the newly accepted value.
        level_r <= sync2_r;
        cnt_r   <= {STAB_CNT_W{1'b0}};
        press_r <= ~sync2_r;
        rel_r   <= sync2_r;
      end else if (tick) begin
        cnt_r <= cnt_r + stab_cnt_t'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;
  assign rel   = rel_r;

endmodule

// File: rtl/switch_conditioner.sv
// Four-channel switch debouncer sharing a single debounce tick generator.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] SWITCH,
  output logic [NUM_CH-1:0] oSWITCH,
  output logic [NUM_CH-1:0] PRESS,
  output logic [NUM_CH-1:0] RELEASE
);

  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_s;

  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Free-running divider: counts 0..TICK_DIV-1 and wraps
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    switch_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_ch (
      .clk  (CLK),
      .rst_n(RST_N),
      .tick (tick_s),
      .raw  (SWITCH[i]),
      .level(oSWITCH[i]),
      .press(PRESS[i]),
      .rel  (RELEASE[i])
    );
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed self-checking bench for switch_conditioner with TICK_DIV=4,
// DEBOUNCE_TICKS=3 (acceptance 12..15 cycles after a clean input edge).
module tb_switch_conditioner;

  localparam int TD = 4;
  localparam int DT = 3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] SWITCH;
  logic [3:0] oSWITCH;
  logic [3:0] PRESS;
  logic [3:0] RELEASE;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  switch_conditioner #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .SWITCH (SWITCH),
    .oSWITCH(oSWITCH),
    .PRESS  (PRESS),
    .RELEASE(RELEASE)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run n cycles requiring a steady oSWITCH and no pulses throughout.
  task automatic idle(input string tag, input int n, input logic [3:0] exp_o);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (oSWITCH !== exp_o || PRESS !== 4'b0000 || RELEASE !== 4'b0000) ok = 1'b0;
    end
    check(tag, ok, 1'b1);
  endtask

  // Wait (bounded) for oSWITCH to change; check latency, new level and one-cycle pulses.
  task automatic wait_change(input string tag, input logic [3:0] exp_o,
                             input logic [3:0] exp_p, input logic [3:0] exp_r);
    logic [3:0] prev;
    int         lat;
    logic       quiet;
    prev  = oSWITCH;
    lat   = 0;
    quiet = 1'b1;
    do begin
      step();
      lat++;
      if (oSWITCH === prev && (PRESS !== 4'b0000 || RELEASE !== 4'b0000)) quiet = 1'b0;
    end while (oSWITCH === prev && lat < 20);
    check({tag, " quiet_before"}, quiet, 1'b1);
    check({tag, " latency_in_11_15"}, (lat >= 11 && lat <= 15), 1'b1);
    check({tag, " oSWITCH"}, oSWITCH, exp_o);
    check({tag, " PRESS"}, PRESS, exp_p);
    check({tag, " RELEASE"}, RELEASE, exp_r);
    step();
    check({tag, " PRESS_after"}, PRESS, 4'b0000);
    check({tag, " RELEASE_after"}, RELEASE, 4'b0000);
    check({tag, " oSWITCH_after"}, oSWITCH, exp_o);
  endtask

  initial begin
    // Reset held with all switches pressed
    RST_N  = 1'b0;
    SWITCH = 4'b0000;
    step(); step(); step();
    check("rst oSWITCH", oSWITCH, 4'b1111);
    check("rst PRESS", PRESS, 4'b0000);
    check("rst RELEASE", RELEASE, 4'b0000);

    // Release reset with switches idle: nothing happens
    SWITCH = 4'b1111;
    RST_N  = 1'b1;
    idle("post_rst_quiet", 20, 4'b1111);

    // Single press/release on channel 3
    SWITCH = 4'b0111;
    wait_change("press3", 4'b0111, 4'b1000, 4'b0000);
    SWITCH = 4'b1111;
    wait_change("rel3", 4'b1111, 4'b0000, 4'b1000);

    // Short glitches on channel 0: 1 tick and 2 ticks low are rejected
    SWITCH = 4'b1110;
    idle("glitch_1tick_low", 4, 4'b1111);
    SWITCH = 4'b1111;
    idle("glitch_1tick_gap", 10, 4'b1111);
    SWITCH = 4'b1110;
    idle("glitch_2tick_low", 8, 4'b1111);
    SWITCH = 4'b1111;
    idle("glitch_2tick_after", 20, 4'b1111);

    // Channels 1 and 2 together
    SWITCH = 4'b1001;
    wait_change("press12", 4'b1001, 4'b0110, 4'b0000);
    SWITCH = 4'b1111;
    wait_change("rel12", 4'b1111, 4'b0000, 4'b0110);

    // Reset in the middle of qualifying channel 3
    SWITCH = 4'b0111;
    idle("pre_rst_2ticks", 8, 4'b1111);
    RST_N = 1'b0;
    step(); step();
    check("midrst oSWITCH", oSWITCH, 4'b1111);
    check("midrst PRESS", PRESS, 4'b0000);
    check("midrst RELEASE", RELEASE, 4'b0000);
    RST_N = 1'b1;
    // sync 2 cycles, ticks at edges 4/8/12, accept on edge 13
    idle("requalify_hold", 12, 4'b1111);
    step();
    check("requalify oSWITCH", oSWITCH, 4'b0111);
    check("requalify PRESS", PRESS, 4'b1000);
    check("requalify RELEASE", RELEASE, 4'b0000);
    step();
    check("requalify PRESS_after", PRESS, 4'b0000);

    // Return channel 3 to released
    SWITCH = 4'b1111;
    wait_change("rel3_after_rst", 4'b1111, 4'b0000, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
